// File: rtl/instr_mem_ctrl_if.sv
// Fetch and debug signal bundle for instr_mem_ctrl.
// The master modport belongs to the CPU/debug side and the slave modport to the memory.
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 8
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_stall;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic              if_fault;
  logic              if_perr;
  logic              dbg_we;
  logic              dbg_re;
  logic [IDX_W-1:0]  dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_rvalid;

  modport master (
    output if_req, if_addr, if_stall, dbg_we, dbg_re, dbg_addr, dbg_wdata,
    input  if_ready, if_valid, if_instr, if_fault, if_perr, dbg_rdata, dbg_rvalid
  );

  modport slave (
    input  if_req, if_addr, if_stall, dbg_we, dbg_re, dbg_addr, dbg_wdata,
    output if_ready, if_valid, if_instr, if_fault, if_perr, dbg_rdata, dbg_rvalid
  );
endinterface

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with a registered, stall-holding fetch port and a debug read/write port.
// Optional macro IMEM_PARITY_EN adds a per-word even-parity bit and reports mismatches on if_perr.
module instr_mem_ctrl #(
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 256,
  parameter int              ADDR_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = 'h00000013,
  localparam int             IDX_W    = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rstn,
  instr_mem_ctrl_if.slave bus
);

  // state | meaning
  // EMPTY | no fetch response presented
  // FULL  | response presented on if_instr/if_fault/if_perr
  typedef enum logic {EMPTY, FULL} state_t;

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;

  logic              hold;
  logic              ready;
  logic              accept;
  logic              addr_fault;
  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  fetch_idx;
  logic [MEM_W-1:0]  fetch_word;
  logic              fetch_perr;
  logic [MEM_W-1:0]  wr_word;

  assign word_addr  = bus.if_addr >> 2;
  assign fetch_idx  = bus.if_addr[IDX_W+1:2];
  assign addr_fault = (bus.if_addr[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH));
  assign fetch_word = mem_q[fetch_idx];

`ifdef IMEM_PARITY_EN
  assign wr_word    = {^bus.dbg_wdata, bus.dbg_wdata};
  assign fetch_perr = ^fetch_word;
`else
  assign wr_word    = bus.dbg_wdata;
  assign fetch_perr = 1'b0;
`endif

  // A debug write owns the memory for the cycle, so fetch backs off.
  assign hold   = (state_q == FULL) && bus.if_stall;
  assign ready  = !bus.dbg_we && !hold;
  assign accept = bus.if_req && ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fault_d = fault_q;
    perr_d  = perr_q;
    if (accept) begin
      state_d = FULL;
      fault_d = addr_fault;
      instr_d = addr_fault ? NOP_WORD : fetch_word[DATA_W-1:0];
      perr_d  = !addr_fault && fetch_perr;
    end else if (!hold) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= EMPTY;
      instr_q  <= '0;
      fault_q  <= 1'b0;
      perr_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
      perr_q   <= perr_d;
      rvalid_q <= bus.dbg_re;
      if (bus.dbg_re) begin
        rdata_q <= mem_q[bus.dbg_addr][DATA_W-1:0];
      end
    end
  end

  // Contents survive reset; read-first ordering falls out of the non-blocking update.
  always_ff @(posedge clk) begin
    if (bus.dbg_we) begin
      mem_q[bus.dbg_addr] <= wr_word;
    end
  end

  assign bus.if_ready   = ready;
  assign bus.if_valid   = (state_q == FULL);
  assign bus.if_instr   = instr_q;
  assign bus.if_fault   = fault_q;
  assign bus.if_perr    = perr_q;
  assign bus.dbg_rdata  = rdata_q;
  assign bus.dbg_rvalid = rvalid_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: a word-array model predicts responses, a monitor checks them.
// Define IMEM_PARITY_EN for both files to include the parity corruption case.
module tb_instr_mem_ctrl;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic              fault;
    logic              perr;
  } resp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  instr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) bus ();

  instr_mem_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .NOP_WORD(NOP)
  ) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  resp_t             fq[$];
  logic [DATA_W-1:0] dq[$];
  logic [DATA_W-1:0] m_mem [DEPTH];
  bit                m_bad [DEPTH];
  bit                m_full;
  bit                exp_ready;
  bit                check_ready;
  bit                prev_hold;
  resp_t             last_resp;
  int                n_checks;
  int                n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model applies the handshake rules to the same inputs.
  task automatic cycle(input bit req, input logic [ADDR_W-1:0] addr, input bit stall,
                       input bit we, input bit re, input logic [IDX_W-1:0] da,
                       input logic [DATA_W-1:0] wd);
    bit    hold, f;
    resp_t r;
    @(posedge clk);
    #1;
    bus.if_req    = req;
    bus.if_addr   = addr;
    bus.if_stall  = stall;
    bus.dbg_we    = we;
    bus.dbg_re    = re;
    bus.dbg_addr  = da;
    bus.dbg_wdata = wd;
    hold        = m_full && stall;
    exp_ready   = !we && !hold;
    check_ready = 1'b1;
    if (req && exp_ready) begin
      f = (addr % 4 != 0) || ((addr / 4) >= DEPTH);
      r.fault = f;
      r.instr = f ? NOP : m_mem[(addr / 4) % DEPTH];
      r.perr  = !f && m_bad[(addr / 4) % DEPTH];
      fq.push_back(r);
    end
    m_full = (req && exp_ready) || hold;
    if (re) dq.push_back(m_mem[da]);
    if (we) begin
      m_mem[da] = wd;
      m_bad[da] = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0, 0, '0, '0);
  endtask

  always @(negedge clk) begin
    resp_t r, cur;
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      cur = '{instr: bus.if_instr, fault: bus.if_fault, perr: bus.if_perr};
      if (check_ready) check("if_ready", 64'(bus.if_ready), 64'(exp_ready));
      if (prev_hold) begin
        check("held_valid", 64'(bus.if_valid), 64'd1);
        check("held_resp", 64'(cur), 64'(last_resp));
      end else if (bus.if_valid) begin
        if (fq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_unexpected: got response %h, expected none", cur);
        end else begin
          r = fq.pop_front();
          check("fetch_resp", 64'(cur), 64'(r));
          last_resp = cur;
        end
      end
      if (bus.dbg_rvalid) begin
        if (dq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL dbg_unexpected: got rdata %h, expected no pulse", bus.dbg_rdata);
        end else begin
          check("dbg_rdata", 64'(bus.dbg_rdata), 64'(dq.pop_front()));
        end
      end
      prev_hold = bus.if_valid && bus.if_stall;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    int                sel;
    bus.if_req = 0; bus.if_addr = '0; bus.if_stall = 0;
    bus.dbg_we = 0; bus.dbg_re = 0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
    #1 rstn = 1'b0;
    #2;
    check("rst_valid", 64'(bus.if_valid), 64'd0);
    check("rst_instr", 64'(bus.if_instr), 64'd0);
    check("rst_fault", 64'(bus.if_fault), 64'd0);
    check("rst_perr", 64'(bus.if_perr), 64'd0);
    check("rst_rvalid", 64'(bus.dbg_rvalid), 64'd0);
    check("rst_rdata", 64'(bus.dbg_rdata), 64'd0);
    @(posedge clk);
    #3 rstn = 1'b1;

    // Write word 3, then fetch it.
    cycle(0, '0, 0, 1, 0, 4'd3, 32'h00500093);
    cycle(1, 32'h0C, 0, 0, 0, '0, '0);
    // Hold under stall while the word is overwritten; held response must not change.
    for (int i = 0; i < 3; i++) cycle(1, 32'h0C, 1, 1, 0, 4'd3, 32'hDEADBEEF);
    cycle(0, '0, 0, 0, 0, '0, '0);
    cycle(1, 32'h0C, 0, 0, 0, '0, '0);
    // Misaligned and out-of-range fetches, back to back.
    cycle(1, 32'h06, 0, 0, 0, '0, '0);
    cycle(1, 32'(DEPTH * 4), 0, 0, 0, '0, '0);
    cycle(1, 32'hFFFF_FFFC, 0, 0, 0, '0, '0);
    // Write blocks a simultaneous fetch; the fetch next cycle sees the new word.
    cycle(1, 32'h08, 0, 1, 0, 4'd2, 32'hCAFE0002);
    cycle(1, 32'h08, 0, 0, 0, '0, '0);
    // Read-first on same-cycle write/read, then read back the new word.
    cycle(0, '0, 0, 1, 0, 4'd5, 32'h11);
    cycle(0, '0, 0, 1, 1, 4'd5, 32'h22);
    cycle(0, '0, 0, 0, 1, 4'd5, '0);
    // Boundary: last valid word.
    cycle(0, '0, 0, 1, 0, 4'(DEPTH - 1), 32'hA5A5_0F0F);
    cycle(1, 32'((DEPTH - 1) * 4), 0, 0, 0, '0, '0);
    idle(2);

    // Reset while a fetch is in flight: that response must never appear.
    cycle(1, 32'h0C, 0, 0, 0, '0, '0);
    cycle(1, 32'h08, 0, 0, 0, '0, '0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    bus.if_req = 0; bus.dbg_we = 0; bus.dbg_re = 0; bus.if_stall = 0;
    #1;
    check("rst_mid_valid", 64'(bus.if_valid), 64'd0);
    fq.delete();
    m_full    = 1'b0;
    exp_ready = 1'b1;
    #1 rstn = 1'b1;
    idle(3);
    cycle(1, 32'h0C, 0, 0, 0, '0, '0);
    idle(1);

`ifdef IMEM_PARITY_EN
    cycle(0, '0, 0, 1, 0, 4'd7, 32'h1234_5678);
    idle(1);
    dut.mem_q[7] = dut.mem_q[7] ^ 33'd1;
    m_mem[7] = m_mem[7] ^ 32'd1;
    m_bad[7] = 1'b1;
    cycle(1, 32'h1C, 0, 0, 0, '0, '0);
    idle(1);
`endif

    // Fill every word, then randomized traffic.
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 0, 1, 0, 4'(i), $urandom);
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 70)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (sel < 85) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else               a = 32'(DEPTH * 4) + 32'($urandom_range(0, 4095) * 4);
      cycle($urandom_range(0, 99) < 75, a, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
            4'($urandom_range(0, DEPTH - 1)), $urandom);
    end
    idle(4);

    check("fetch_drain", 64'(fq.size()), 64'd0);
    check("dbg_drain", 64'(dq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
- Parametrised instruction memory with a handshaked CPU fetch port and an independent debug (SDU) read/write port.
- Sits between the IF stage and the debug/loader unit; replaces the single-port combinational-read instruction RAM.
- Registered 1-cycle fetch latency, stall hold, fault flagging, and debug-write priority over fetch.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 256, number of words; power of two, at least 4.
- ADDR_W, 32, fetch byte-address width.
- NOP_WORD, 32'h00000013, word returned on a faulted fetch.
- IDX_W (localparam), clog2(DEPTH), word-index width.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- if_req  input  1  fetch request.
- if_addr  input  ADDR_W  fetch byte address.
- if_ready  output  1  request accepted this cycle (combinational).
- if_stall  input  1  consumer not taking the current response.
- if_valid  output  1  if_instr/if_fault valid.
- if_instr  output  DATA_W  fetched word.
- if_fault  output  1  misaligned or out-of-range fetch.
- if_perr  output  1  parity error on fetched word (see Optional Feature).
- dbg_we  input  1  debug write strobe.
- dbg_re  input  1  debug read strobe.
- dbg_addr  input  IDX_W  debug word address.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_rdata  output  DATA_W  debug read data.
- dbg_rvalid  output  1  one-cycle pulse, dbg_rdata valid.

Behaviour:
- Reset (rstn=0, asynchronous): if_valid=0, if_instr=0, if_fault=0, if_perr=0, dbg_rvalid=0, dbg_rdata=0, FSM=EMPTY. Memory contents are not cleared. An in-flight fetch or debug read is dropped and produces no response after reset releases.
- Fetch FSM has two states, EMPTY and FULL:
  - Condition for holding: FULL && if_stall.
  - if_ready = !dbg_we && !(FULL && if_stall).
  - Accept: if_req && if_ready. Next cycle FSM=FULL and if_valid=1 with the response.
  - FULL && if_stall: if_valid, if_instr, if_fault and if_perr held bit-stable and the request is not accepted.
  - No accept and not holding: next cycle FSM=EMPTY, if_valid=0, and if_instr keeps its last value.
  - Back-to-back accepts give one response per cycle, in order.
- Word index = if_addr[IDX_W+1:2].
- Fault condition: if_addr[1:0]!=0 or (if_addr>>2)>=DEPTH. On fault, the response is if_fault=1, if_instr=NOP_WORD, if_perr=0, and if_valid=1. A faulting fetch still follows the normal handshake.
- Debug write: mem[dbg_addr]<=dbg_wdata at the rising edge. A fetch cannot be accepted in the same cycle because if_ready=0.
- Debug read: the cycle after dbg_re, dbg_rvalid=1 and dbg_rdata=mem[dbg_addr] as sampled at the request edge.
  - dbg_we and dbg_re in the same cycle to the same address is read-first: dbg_rdata returns the old word.
- Write then read:
  - A fetch or debug read one cycle after a write to the same word returns the new data.
  - A fetch response already held under stall is not updated by a later write.
- dbg_we held high continuously stalls fetch indefinitely. dbg_re never blocks fetch.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from dbg_wdata on write.
  - A fetch recomputes parity and sets if_perr=1 in the response on mismatch. if_instr is the raw stored word and if_fault is unaffected.
  - dbg_rdata carries data bits only.
- Not defined: no parity storage, and if_perr is tied to 0.

Test Plan:
- Reset, then debug-write 0x00500093 to word 3, then fetch if_addr=0x0C with if_stall=0 -> next cycle if_valid=1, if_instr=0x00500093, if_fault=0.
- Fetch 0x0C held FULL with if_stall=1 for 3 cycles while debug-writing 0xDEADBEEF to word 3 -> if_ready=0 throughout, if_instr stays 0x00500093. Release stall, refetch -> 0xDEADBEEF.
- Fetch if_addr=0x06 and then if_addr=DEPTH*4 -> each response has if_valid=1, if_fault=1, if_instr=0x00000013.
- dbg_we=1 and if_req=1 in the same cycle -> if_ready=0, write completes, fetch accepted the following cycle.
- dbg_we+dbg_re to word 5 (old 0x11, new 0x22) -> dbg_rvalid pulse with dbg_rdata=0x11. dbg_re next cycle -> 0x22.
- Accept a fetch, then drive rstn=0 for a partial cycle before the response -> if_valid=0 immediately and no response after release. With IMEM_PARITY_EN, force-flip a stored bit -> if_perr=1 on fetch.
